window_firing_fsm_multi: RTL

Level-2 firing-state FSM for the window computation actor. It is the parametrised successor to the fixed-length, sum-only firing FSM. It runs one CFDF mode per firing:
- SETUP_COMP: load a window of runtime length L from the data FIFO into local RAM.
- COMP: reduce the stored window using a runtime-selected command (SUM, MAX, MIN, NONZERO count).
- OUTPUT: write the result to the output FIFO under full-flag backpressure.

It sits under the invoke FSM, which pulses `start_in` and waits for `done_out`.

---
 rtl/window_firing_fsm_multi_if.sv | 27 ++
 rtl/window_firing_fsm_multi.sv | 111 +++++++++++
 2 files changed

// File: rtl/window_firing_fsm_multi_if.sv
// window_firing_fsm_multi_if: parent handshake and FIFO-side signals of the window firing FSM
interface window_firing_fsm_multi_if #(
  parameter int size  = 8,
  parameter int width = 16
);
  localparam int LW = $clog2(size + 1);
  logic             start_in;
  logic [1:0]       next_mode_in;
  logic [LW-1:0]    length_in;
  logic [1:0]       command_in;
  logic [width-1:0] data_in_fifo;
  logic             out_fifo_full;
  logic             rd_in_data_fifo;
  logic             wr_out_fifo;
  logic [width-1:0] data_out;
  logic [1:0]       next_mode_out;
  logic             done_out;
  logic             error_out;
  modport master (
    output start_in, next_mode_in, length_in, command_in, data_in_fifo, out_fifo_full,
    input  rd_in_data_fifo, wr_out_fifo, data_out, next_mode_out, done_out, error_out
  );
  modport slave (
    input  start_in, next_mode_in, length_in, command_in, data_in_fifo, out_fifo_full,
    output rd_in_data_fifo, wr_out_fifo, data_out, next_mode_out, done_out, error_out
  );
endinterface

// File: rtl/window_firing_fsm_multi.sv
// window_firing_fsm_multi: CFDF firing FSM that loads a window, reduces it by command, and emits the result
module window_firing_fsm_multi #(
  parameter int size  = 8,
  parameter int width = 16
) (
  input logic                     clk,
  input logic                     rst,
  window_firing_fsm_multi_if.slave bus
);
  localparam int LW = $clog2(size + 1);
  localparam int AW = $clog2(size);
  typedef enum logic [2:0] {IDLE, LOAD, COMP, DRAIN, OUT_WAIT, END} state_t;
  state_t           state_q;
  logic [LW-1:0]    l_q;
  logic [1:0]       cmd_q;
  logic [1:0]       mode_q;
  logic [1:0]       nm_q;
  logic [width-1:0] acc_q;
  logic [AW-1:0]    addr_q;
  logic             vld_q;
  logic             err_q;
  logic [width-1:0] ram [size];
  logic [width-1:0] ram_q;
  logic             len_ok;
  logic             last;
  function automatic logic [width-1:0] accum(input logic [1:0] c, input logic [width-1:0] a,
                                             input logic [width-1:0] w);
    return c == 2'b00 ? a + w :
           c == 2'b01 ? (w > a ? w : a) :
           c == 2'b10 ? (w < a ? w : a) :
                        a + width'(|w);
  endfunction
  assign len_ok = bus.length_in != '0 && bus.length_in <= LW'(size);
  assign last   = addr_q == AW'(l_q - 1'b1);
  // window storage: written during LOAD, read every cycle with one-cycle latency
  always_ff @(posedge clk) begin
    if (state_q == LOAD) ram[addr_q] <= bus.data_in_fifo;
    ram_q <= ram[addr_q];
  end
  // firing FSM: mode dispatch, load/reduce sequencing, result hand-off and next-mode bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      cmd_q   <= 2'b00;
      mode_q  <= 2'b00;
      nm_q    <= 2'b00;
      acc_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_in) begin
          addr_q <= '0;
          vld_q  <= 1'b0;
          mode_q <= bus.next_mode_in;
          case (bus.next_mode_in)
            2'b00: if (len_ok) begin
              l_q     <= bus.length_in;
              state_q <= LOAD;
            end else begin
              err_q   <= 1'b1;
              state_q <= END;
            end
            2'b01: if (l_q != '0) begin
              cmd_q   <= bus.command_in;
              acc_q   <= bus.command_in == 2'b10 ? '1 : '0;
              state_q <= COMP;
            end else begin
              err_q   <= 1'b1;
              state_q <= END;
            end
            2'b10: state_q <= OUT_WAIT;
            default: begin
              err_q   <= 1'b1;
              state_q <= END;
            end
          endcase
        end
        LOAD: begin
          addr_q <= addr_q + 1'b1;
          if (last) state_q <= END;
        end
        COMP: begin
          addr_q <= addr_q + 1'b1;
          vld_q  <= 1'b1;
          if (vld_q) acc_q <= accum(cmd_q, acc_q, ram_q);
          if (last) state_q <= DRAIN;
        end
        DRAIN: begin
          acc_q   <= accum(cmd_q, acc_q, ram_q);
          state_q <= END;
        end
        OUT_WAIT: if (!bus.out_fifo_full) state_q <= END;
        END: begin
          if (!err_q) nm_q <= mode_q == 2'b10 ? 2'b00 : mode_q + 2'b01;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rd_in_data_fifo = state_q == LOAD;
  assign bus.wr_out_fifo     = state_q == OUT_WAIT && !bus.out_fifo_full;
  assign bus.data_out        = bus.wr_out_fifo ? acc_q : '0;
  assign bus.done_out        = state_q == END;
  assign bus.error_out       = state_q == END && err_q;
  assign bus.next_mode_out   = nm_q;
endmodule
